// File: rtl/sram_word_master.sv
// rtl/sram_word_master.sv - 32-bit word initiator for a 16-bit asynchronous SRAM
// Splits one word request into up to two timed halfword accesses, big-endian (HI half at the even address).
module sram_word_master #(
    parameter int ADDR_WIDTH  = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [31:0]           req_addr,
    input  logic [3:0]            req_be,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [15:0]           data,
    output logic                  wre,
    output logic                  oute,
    output logic                  hb_mask,
    output logic                  lb_mask,
    output logic                  chip_en
);

    localparam int CW = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RESP} state_t;

    state_t                state_q;
    logic                  we_q;
    logic [3:0]            be_q;
    logic [31:0]           wdata_q;
    logic [ADDR_WIDTH-2:0] word_q;
    logic                  lo_q;
    logic [CW-1:0]         cnt_q;
    logic [31:0]           rbuf_q;
    logic                  chip_en_q;
    logic                  wre_q;
    logic                  oute_q;
    logic                  hb_q;
    logic                  lb_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [15:0]           dout_q;
    logic                  data_oe_q;
    logic                  resp_valid_q;
    logic [31:0]           resp_rdata_q;

    logic [15:0] lane_mask;
    logic        unused_addr_bits;

    // Disabled byte lanes of an accessed half read back as zero.
    assign lane_mask        = {{8{~hb_q}}, {8{~lb_q}}};
    assign unused_addr_bits = ^{req_addr[31:ADDR_WIDTH+1], req_addr[1:0]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            be_q         <= 4'b0;
            wdata_q      <= 32'b0;
            word_q       <= '0;
            lo_q         <= 1'b0;
            cnt_q        <= '0;
            rbuf_q       <= 32'b0;
            chip_en_q    <= 1'b1;
            wre_q        <= 1'b1;
            oute_q       <= 1'b1;
            hb_q         <= 1'b1;
            lb_q         <= 1'b1;
            addr_q       <= '0;
            dout_q       <= 16'b0;
            data_oe_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        be_q    <= req_be;
                        wdata_q <= req_wdata;
                        word_q  <= req_addr[ADDR_WIDTH:2];
                        rbuf_q  <= 32'b0;
                        if (|req_be) begin
                            state_q   <= SETUP;
                            chip_en_q <= 1'b0;
                            data_oe_q <= req_we;
                            if (|req_be[3:2]) begin
                                lo_q   <= 1'b0;
                                addr_q <= {req_addr[ADDR_WIDTH:2], 1'b0};
                                hb_q   <= ~req_be[3];
                                lb_q   <= ~req_be[2];
                                dout_q <= req_wdata[31:16];
                            end else begin
                                lo_q   <= 1'b1;
                                addr_q <= {req_addr[ADDR_WIDTH:2], 1'b1};
                                hb_q   <= ~req_be[1];
                                lb_q   <= ~req_be[0];
                                dout_q <= req_wdata[15:0];
                            end
                        end else begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_rdata_q <= 32'b0;
                        end
                    end
                end
                SETUP: begin
                    state_q <= STROBE;
                    cnt_q   <= CW'(WAIT_CYCLES);
                    wre_q   <= ~we_q;
                    oute_q  <= we_q;
                end
                STROBE: begin
                    if (cnt_q == CW'(1)) begin
                        state_q <= HOLD;
                        wre_q   <= 1'b1;
                        oute_q  <= 1'b1;
                        if (!we_q) begin
                            if (lo_q) rbuf_q[15:0]  <= data & lane_mask;
                            else      rbuf_q[31:16] <= data & lane_mask;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                HOLD: begin
                    if (!lo_q && (|be_q[1:0])) begin
                        state_q <= SETUP;
                        lo_q    <= 1'b1;
                        addr_q  <= {word_q, 1'b1};
                        hb_q    <= ~be_q[1];
                        lb_q    <= ~be_q[0];
                        dout_q  <= wdata_q[15:0];
                    end else begin
                        state_q      <= RESP;
                        chip_en_q    <= 1'b1;
                        hb_q         <= 1'b1;
                        lb_q         <= 1'b1;
                        data_oe_q    <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= rbuf_q;
                    end
                end
                RESP: begin
                    state_q      <= IDLE;
                    resp_valid_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE) && !reset;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign addr       = addr_q;
    assign wre        = wre_q;
    assign oute       = oute_q;
    assign hb_mask    = hb_q;
    assign lb_mask    = lb_q;
    assign chip_en    = chip_en_q;
    assign data       = data_oe_q ? dout_q : 16'bz;

endmodule

// File: tb/tb_sram_word_master.sv
// tb/tb_sram_word_master.sv - self-checking bench for sram_word_master
// Directed plan steps followed by random word traffic against a word-level memory model.
module tb_sram_word_master;

    localparam int AW = 18;
    localparam int WC = 2;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [31:0]   req_addr = 32'b0;
    logic [3:0]    req_be = 4'b0;
    logic [31:0]   req_wdata = 32'b0;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic [AW-1:0] addr;
    wire  [15:0]   data;
    logic          wre, oute, hb_mask, lb_mask, chip_en;

    int checks = 0;
    int failures = 0;
    int txn = 0;

    sram_word_master #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WC)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .addr(addr), .data(data), .wre(wre), .oute(oute),
        .hb_mask(hb_mask), .lb_mask(lb_mask), .chip_en(chip_en)
    );

    always #5 clock = ~clock;

    // SRAM responder: drives the full halfword on reads, writes enabled bytes while wre is low.
    logic [15:0] ram     [0:(1<<AW)-1];
    logic [15:0] ref_mem [0:(1<<AW)-1];

    assign data = (!chip_en && !oute && wre) ? ram[addr] : 16'bz;

    always @(posedge clock) begin
        if (!chip_en && !wre) begin
            if (!hb_mask) ram[addr][15:8] <= data[15:8];
            if (!lb_mask) ram[addr][7:0]  <= data[7:0];
        end
    end

    // Bus monitor, sampled on the falling edge.
    int   wre_lo = 0, oute_lo = 0, ce_lo = 0, viol = 0, resp_cnt = 0;
    logic seen_hb = 1'b1, seen_lb = 1'b1;
    logic prev_strobe = 1'b0;
    logic [AW+17:0] prev_bus = '0;

    always @(negedge clock) begin
        if (!wre) wre_lo++;
        if (!oute) oute_lo++;
        if (!chip_en) ce_lo++;
        if (resp_valid) resp_cnt++;
        if (!wre && !oute) viol++;
        if ((!wre || !oute) && chip_en) viol++;
        if (!oute && dut.data_oe_q) viol++;
        if (!wre || !oute) begin
            seen_hb = hb_mask;
            seen_lb = lb_mask;
            if (prev_strobe && ({addr, hb_mask, lb_mask, data} != prev_bus)) viol++;
        end
        prev_strobe = !wre || !oute;
        prev_bus    = {addr, hb_mask, lb_mask, data};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s txn=%0d observed=%h expected=%h", tag, txn, obs, exp);
        end
    endtask

    // One complete request checked against the memory model.
    task automatic run(input logic we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        logic [AW-1:0] hi_i, lo_i;
        logic [31:0]   exp_rd;
        int            nh, exp_lat, lat;
        txn++;
        hi_i = {a[AW:2], 1'b0};
        lo_i = {a[AW:2], 1'b1};
        nh = ((be[3:2] != 0) ? 1 : 0) + ((be[1:0] != 0) ? 1 : 0);
        exp_lat = 1 + nh * (WC + 2);
        exp_rd = 32'b0;
        if (!we) begin
            if (be[3]) exp_rd[31:24] = ref_mem[hi_i][15:8];
            if (be[2]) exp_rd[23:16] = ref_mem[hi_i][7:0];
            if (be[1]) exp_rd[15:8]  = ref_mem[lo_i][15:8];
            if (be[0]) exp_rd[7:0]   = ref_mem[lo_i][7:0];
        end else begin
            if (be[3]) ref_mem[hi_i][15:8] = wd[31:24];
            if (be[2]) ref_mem[hi_i][7:0]  = wd[23:16];
            if (be[1]) ref_mem[lo_i][15:8] = wd[15:8];
            if (be[0]) ref_mem[lo_i][7:0]  = wd[7:0];
        end
        @(negedge clock);
        check("req_ready_idle", {31'b0, req_ready}, 32'd1);
        wre_lo = 0; oute_lo = 0; ce_lo = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_be = be; req_wdata = wd;
        @(posedge clock);
        #1;
        req_valid = 1'b0; req_we = $urandom_range(0, 1); req_addr = $urandom();
        req_be = 4'($urandom()); req_wdata = $urandom();
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clock);
            if (resp_valid) begin
                lat = i;
                break;
            end
        end
        check("latency", lat, exp_lat);
        check("resp_rdata", resp_rdata, exp_rd);
        check("wre_low_cycles", wre_lo, we ? WC * nh : 0);
        check("oute_low_cycles", oute_lo, we ? 0 : WC * nh);
        check("chip_en_low_cycles", ce_lo, nh * (WC + 2));
        @(negedge clock);
        check("resp_pulse_width", {31'b0, resp_valid}, 32'd0);
        check("resp_rdata_held", resp_rdata, exp_rd);
        if (we) begin
            check("ram_hi", {16'b0, ram[hi_i]}, {16'b0, ref_mem[hi_i]});
            check("ram_lo", {16'b0, ram[lo_i]}, {16'b0, ref_mem[lo_i]});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          rc, waited;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i] = 16'h0;
            ref_mem[i] = 16'h0;
        end
        #13;
        check("rst_controls", {27'b0, wre, oute, hb_mask, lb_mask, chip_en}, 32'h1f);
        check("rst_req_ready", {31'b0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_addr", {14'b0, addr}, 32'd0);
        check("rst_data_released", {31'b0, dut.data_oe_q}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("post_rst_ready", {31'b0, req_ready}, 32'd1);

        run(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF);
        check("plan_ram8", {16'b0, ram[8]}, 32'h0000DEAD);
        check("plan_ram9", {16'b0, ram[9]}, 32'h0000BEEF);
        run(1'b0, 32'h10, 4'b1111, 32'h0);
        check("plan_readback", resp_rdata, 32'hDEADBEEF);
        run(1'b1, 32'h10, 4'b0010, 32'h00001200);
        check("plan_partial_ram9", {16'b0, ram[9]}, 32'h000012EF);
        check("plan_partial_masks", {30'b0, seen_hb, seen_lb}, 32'd1);
        run(1'b0, 32'h10, 4'b1111, 32'h0);
        check("plan_partial_read", resp_rdata, 32'hDEAD12EF);
        run(1'b0, 32'h20, 4'b0000, 32'h0);
        check("plan_null_rdata", resp_rdata, 32'h0);

        // Reset while the first write strobe is low: the transaction is dropped.
        txn++;
        @(negedge clock);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_be = 4'b1111; req_wdata = 32'h12345678;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        waited = 0;
        while (wre && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        check("abort_wre_seen_low", {31'b0, wre}, 32'd0);
        rc = resp_cnt;
        #2;
        reset = 1'b1;
        #1;
        check("abort_controls", {27'b0, wre, oute, hb_mask, lb_mask, chip_en}, 32'h1f);
        check("abort_data_released", {31'b0, dut.data_oe_q}, 32'd0);
        check("abort_req_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 12; i++) @(negedge clock);
        check("abort_no_resp", resp_cnt, rc);
        run(1'b1, 32'h40, 4'b1111, 32'hCAFEF00D);
        run(1'b0, 32'h40, 4'b1111, 32'h0);
        check("abort_recover_read", resp_rdata, 32'hCAFEF00D);

        for (int n = 0; n < 60; n++) begin
            a = ($urandom() & ~32'h0007FFFC) | (32'($urandom_range(0, 15)) << 2);
            run(1'($urandom_range(0, 1)), a, 4'($urandom()), $urandom());
        end

        check("bus_invariants", viol, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
